// File: rtl/spi_reg_pkg.sv
// Shared types and elaboration helpers for the SPI register bank.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        COMMIT
    } state_t;

    localparam int DEF_BASE_ADDR = 'h10;
    localparam int DEF_SRST_ADDR = 'h0B;

    function automatic int frame_w(input int addr_w, input int reg_w);
        return addr_w + 2 * reg_w;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/spi_reg_bank_if.sv
// SPI pin bundle between the MCU-side master and the register bank.
interface spi_reg_bank_if ();
    logic sclk;
    logic cs_n;
    logic mosi;
    logic miso;

    modport master (output sclk, output cs_n, output mosi, input miso);
    modport slave  (input sclk, input cs_n, input mosi, output miso);
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser plus history flop; rise/fall pulses compare the
// second sync stage against the history flop.
module spi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);
    logic s1;
    logic s2;
    logic hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            hist <= 1'b0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            hist <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~hist;
    assign fall  = ~s2 & hist;
endmodule

// File: rtl/spi_reg_bank.sv
// SPI-controlled register bank in the system clock domain: oversampled SPI
// slave with set/clear/toggle, one-hot and soft-reset commits plus readback.
//   state  | meaning
//   IDLE   | waiting for cs_n fall
//   ADDR   | shifting address bits, miso held high
//   DATA   | shifting clr/set bits, readback shifter on miso
//   COMMIT | one clk to apply or reject the frame
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int                    NREG        = 8,
    parameter int                    REG_W       = 8,
    parameter int                    ADDR_W      = 8,
    parameter int                    BASE_ADDR   = DEF_BASE_ADDR,
    parameter int                    SRST_ADDR   = DEF_SRST_ADDR,
    parameter logic [NREG-1:0]       ONEHOT_MASK = '0,
    parameter logic [NREG*REG_W-1:0] RESET_VAL   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_reg_bank_if.slave         spi,
    output logic [NREG*REG_W-1:0] regs,
    output logic [NREG-1:0]       wr_strobe,
    output logic                  srst_strobe,
    output logic                  frame_err
);
    localparam int FRAME_W = frame_w(ADDR_W, REG_W);
    localparam int SH_W    = 2 * REG_W;
    localparam int CNT_W   = clog2(FRAME_W + 2);
    localparam int IDX_W   = (NREG > 1) ? clog2(NREG) : 1;

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic unused_sync;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   bitcnt;
    logic [ADDR_W-1:0]  addr_q, addr_next;
    logic [ADDR_W:0]    addr_ext;
    logic [SH_W-1:0]    data_sh, rd_sh, rd_img;
    logic [REG_W-1:0]   reg_q [NREG];
    logic [REG_W-1:0]   clr_f, set_f, tog_f, cur_val, oh_val, new_val;
    logic [IDX_W-1:0]   wr_idx;
    logic               wr_hit;
    logic cnt_clr, cnt_inc, addr_shift, data_shift, rd_load, rd_shift, commit, err;

    spi_sync_edge u_sync_sclk (.clk(clk), .rst(rst), .raw(spi.sclk),
                               .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
    spi_sync_edge u_sync_cs   (.clk(clk), .rst(rst), .raw(spi.cs_n),
                               .level(cs_lvl), .rise(cs_rise), .fall(cs_fall));
    spi_sync_edge u_sync_mosi (.clk(clk), .rst(rst), .raw(spi.mosi),
                               .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall));

    assign unused_sync = &{1'b0, sclk_lvl, cs_lvl, mosi_rise, mosi_fall, addr_ext[ADDR_W]};

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (int'(a) >= BASE_ADDR) && (int'(a) < BASE_ADDR + NREG);
    endfunction

    function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
        int d;
        d = int'(a) - BASE_ADDR;
        return d[IDX_W-1:0];
    endfunction

    assign addr_ext  = {addr_q, mosi_lvl};
    assign addr_next = addr_ext[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // cs_n rise is tested before any SCLK edge so a coincident edge is dropped.
    always_comb begin
        state_d    = state_q;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        addr_shift = 1'b0;
        data_shift = 1'b0;
        rd_load    = 1'b0;
        rd_shift   = 1'b0;
        commit     = 1'b0;
        err        = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = ADDR;
                    cnt_clr = 1'b1;
                end
            end
            ADDR: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    err     = (bitcnt != '0);
                end else if (sclk_rise) begin
                    addr_shift = 1'b1;
                    cnt_inc    = 1'b1;
                    if (int'(bitcnt) == ADDR_W - 1) begin
                        rd_load = 1'b1;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (cs_rise) begin
                    state_d = COMMIT;
                end else begin
                    if (sclk_rise) begin
                        data_shift = 1'b1;
                        cnt_inc    = 1'b1;
                    end
                    // The fall right after the last address bit keeps the MSB for the next rise.
                    if (sclk_fall && int'(bitcnt) > ADDR_W) rd_shift = 1'b1;
                end
            end
            COMMIT: begin
                state_d = IDLE;
                if (int'(bitcnt) == FRAME_W) commit = 1'b1;
                else if (bitcnt != '0)       err    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_img = '1;
        if (in_range(addr_next)) rd_img = {reg_q[idx_of(addr_next)], {REG_W{1'b0}}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bitcnt  <= '0;
            addr_q  <= '0;
            data_sh <= '0;
            rd_sh   <= '0;
        end else begin
            if (cnt_clr)
                bitcnt <= '0;
            else if (cnt_inc && int'(bitcnt) != FRAME_W + 1)
                bitcnt <= bitcnt + CNT_W'(1);
            if (addr_shift) addr_q  <= addr_next;
            if (data_shift) data_sh <= {data_sh[SH_W-2:0], mosi_lvl};
            if (rd_load)       rd_sh <= rd_img;
            else if (rd_shift) rd_sh <= {rd_sh[SH_W-2:0], 1'b0};
        end
    end

    // Bits with clr and set both high toggle; the rest follow set-then-clear.
    always_comb begin
        clr_f   = data_sh[SH_W-1:REG_W];
        set_f   = data_sh[REG_W-1:0];
        tog_f   = clr_f & set_f;
        wr_idx  = idx_of(addr_q);
        wr_hit  = in_range(addr_q);
        cur_val = wr_hit ? reg_q[wr_idx] : '0;
        oh_val  = '0;
        for (int b = 0; b < REG_W; b++)
            oh_val[b] = (int'(set_f) == b + 1);
        new_val = ONEHOT_MASK[wr_idx] ? oh_val
                : ((((cur_val & ~clr_f) | set_f) & ~tog_f) | (~cur_val & tog_f));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) reg_q[i] <= RESET_VAL[i*REG_W +: REG_W];
            wr_strobe   <= '0;
            srst_strobe <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            wr_strobe   <= '0;
            srst_strobe <= 1'b0;
            frame_err   <= err;
            if (commit) begin
                if (wr_hit) begin
                    reg_q[wr_idx]     <= new_val;
                    wr_strobe[wr_idx] <= 1'b1;
                end else if (int'(addr_q) == SRST_ADDR) begin
                    for (int i = 0; i < NREG; i++) reg_q[i] <= RESET_VAL[i*REG_W +: REG_W];
                    srst_strobe <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        regs = '0;
        for (int i = 0; i < NREG; i++) regs[i*REG_W +: REG_W] = reg_q[i];
    end

    always_comb begin
        case (state_q)
            ADDR:    spi.miso = 1'b1;
            DATA:    spi.miso = rd_sh[SH_W-1];
            default: spi.miso = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_spi_reg_bank.sv
// Scoreboard bench for spi_reg_bank: SPI master driver with a behavioural
// register model, plus separate monitors for strobes and MISO bits.
module tb_spi_reg_bank;
    localparam int          H     = 6;
    localparam logic [63:0] RST_V = 64'h0000_0000_0000_00A5;
    localparam logic [7:0]  OH    = 8'b0000_0100;

    typedef struct {
        logic [7:0]  wr;
        logic        srst;
        logic        ferr;
        logic [63:0] regs;
        int          cs_cyc;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] regs;
    logic [7:0]  wr_strobe;
    logic        srst_strobe;
    logic        frame_err;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    logic [7:0]  m_regs [8];
    ev_t         ev_q [$];
    logic        miso_q [$];

    spi_reg_bank_if spi_bus ();

    spi_reg_bank #(
        .NREG(8), .REG_W(8), .ADDR_W(8), .BASE_ADDR('h10), .SRST_ADDR('h0B),
        .ONEHOT_MASK(OH), .RESET_VAL(RST_V)
    ) dut (
        .clk(clk), .rst(rst), .spi(spi_bus), .regs(regs),
        .wr_strobe(wr_strobe), .srst_strobe(srst_strobe), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] flat();
        logic [63:0] f;
        for (int i = 0; i < 8; i++) f[i*8 +: 8] = m_regs[i];
        return f;
    endfunction

    function automatic void model_reset();
        logic [63:0] rv;
        rv = RST_V;
        for (int i = 0; i < 8; i++) m_regs[i] = rv[i*8 +: 8];
    endfunction

    function automatic logic [7:0] onehot_of(input logic [7:0] s);
        if (s == 8'd0 || s > 8'd8) return 8'h00;
        return 8'h01 << (s - 8'd1);
    endfunction

    function automatic logic [7:0] setclr(input logic [7:0] cur, input logic [7:0] clr,
                                          input logic [7:0] set);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) begin
            if (clr[b] && set[b]) r[b] = ~cur[b];
            else if (set[b])      r[b] = 1'b1;
            else if (clr[b])      r[b] = 1'b0;
            else                  r[b] = cur[b];
        end
        return r;
    endfunction

    // rst_at >= 1 pulses rst after the fall of that bit; -1 means no reset.
    task automatic send_frame(input logic [7:0] addr, input logic [7:0] clr, input logic [7:0] set,
                              input int nbits, input int rst_at);
        logic [23:0] f;
        logic [15:0] img;
        logic [7:0]  oh;
        ev_t         e;
        bit          have_ev;
        bit          hit;
        int          idx;
        f   = {addr, clr, set};
        oh  = OH;
        idx = int'(addr) - 'h10;
        hit = (addr >= 8'h10) && (addr < 8'h18);
        img = 16'hFFFF;
        if (hit) img = {m_regs[idx], 8'h00};
        for (int k = 1; k <= nbits; k++) begin
            if (rst_at >= 0 && k > rst_at) miso_q.push_back(1'b0);
            else if (k <= 8)               miso_q.push_back(1'b1);
            else if (k <= 24)              miso_q.push_back(img[24-k]);
            else                           miso_q.push_back(1'b0);
        end
        @(negedge clk);
        spi_bus.cs_n = 1'b0;
        repeat (H) @(negedge clk);
        for (int k = 1; k <= nbits; k++) begin
            spi_bus.mosi = (k <= 24) ? f[24-k] : 1'b0;
            repeat (H) @(negedge clk);
            spi_bus.sclk = 1'b1;
            repeat (H) @(negedge clk);
            spi_bus.sclk = 1'b0;
            if (k == rst_at) begin
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
                model_reset();
            end
        end
        repeat (H) @(negedge clk);
        have_ev = 1'b0;
        e.wr    = 8'h00;
        e.srst  = 1'b0;
        e.ferr  = 1'b0;
        if (rst_at >= 1 && rst_at <= nbits) begin
            have_ev = 1'b0;
        end else if (nbits == 0) begin
            have_ev = 1'b0;
        end else if (nbits != 24) begin
            e.ferr  = 1'b1;
            have_ev = 1'b1;
        end else if (hit) begin
            m_regs[idx] = oh[idx] ? onehot_of(set) : setclr(m_regs[idx], clr, set);
            e.wr[idx]   = 1'b1;
            have_ev     = 1'b1;
        end else if (addr == 8'h0B) begin
            model_reset();
            e.srst  = 1'b1;
            have_ev = 1'b1;
        end
        e.regs   = flat();
        e.cs_cyc = cyc;
        if (have_ev) ev_q.push_back(e);
        spi_bus.cs_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    initial begin : strobe_mon
        ev_t e;
        int  lat;
        forever begin
            @(negedge clk);
            if (!rst && (wr_strobe != 8'h00 || srst_strobe || frame_err)) begin
                if (ev_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event wr=%b srst=%b ferr=%b required none",
                             wr_strobe, srst_strobe, frame_err);
                end else begin
                    e = ev_q.pop_front();
                    check("wr_strobe", 64'(wr_strobe), 64'(e.wr));
                    check("srst_strobe", 64'(srst_strobe), 64'(e.srst));
                    check("frame_err", 64'(frame_err), 64'(e.ferr));
                    check("regs_at_event", regs, e.regs);
                    lat = cyc - e.cs_cyc;
                    checks++;
                    if (lat < 1 || lat > 4) begin
                        failures++;
                        $display("FAIL latency actual=%0d clk required 1..4 clk", lat);
                    end
                end
            end
        end
    end

    initial begin : miso_mon
        logic expb;
        forever begin
            @(posedge spi_bus.sclk);
            if (miso_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL miso_unexpected_rise actual=%b required no sclk", spi_bus.miso);
            end else begin
                expb = miso_q.pop_front();
                check("miso", 64'(spi_bus.miso), 64'(expb));
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin : main
        spi_bus.sclk = 1'b0;
        spi_bus.cs_n = 1'b1;
        spi_bus.mosi = 1'b0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_regs", regs, flat());
        check("reset_wr_strobe", 64'(wr_strobe), 64'h0);
        check("reset_srst", 64'(srst_strobe), 64'h0);
        check("reset_frame_err", 64'(frame_err), 64'h0);
        check("reset_miso", 64'(spi_bus.miso), 64'h0);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        send_frame(8'h10, 8'h0F, 8'h30, 24, -1);
        check("setclr_reg0", regs, flat());
        send_frame(8'h11, 8'hFF, 8'h01, 24, -1);
        send_frame(8'h11, 8'h03, 8'h03, 24, -1);
        check("toggle_reg1", regs, flat());
        send_frame(8'h12, 8'h5A, 8'h03, 24, -1);
        check("onehot_3", regs, flat());
        send_frame(8'h12, 8'hFF, 8'h00, 24, -1);
        send_frame(8'h12, 8'h00, 8'h08, 24, -1);
        send_frame(8'h12, 8'h00, 8'h09, 24, -1);
        check("onehot_bounds", regs, flat());

        send_frame(8'h13, 8'hFF, 8'h5C, 24, -1);
        send_frame(8'h13, 8'h00, 8'h00, 24, -1);
        send_frame(8'h40, 8'h12, 8'h34, 24, -1);

        send_frame(8'h10, 8'hFF, 8'hFF, 23, -1);
        send_frame(8'h10, 8'hFF, 8'hFF, 25, -1);
        send_frame(8'h10, 8'hFF, 8'hFF, 0, -1);
        send_frame(8'h10, 8'hFF, 8'hFF, 5, -1);
        check("malformed_unchanged", regs, flat());

        send_frame(8'h0B, 8'hFF, 8'h00, 24, -1);
        check("soft_reset", regs, flat());

        send_frame(8'h14, 8'h00, 8'h77, 24, -1);
        send_frame(8'h15, 8'h00, 8'h66, 24, 12);
        check("rst_mid_frame", regs, flat());
        send_frame(8'h15, 8'h00, 8'h66, 24, -1);
        check("after_rst_frame", regs, flat());

        for (int n = 0; n < 40; n++) begin
            int         r;
            int         nb;
            logic [7:0] a;
            r = int'($urandom_range(0, 11));
            if (r < 8)       a = 8'h10 + r[7:0];
            else if (r == 8) a = 8'h0B;
            else             a = 8'($urandom_range(0, 255));
            nb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 27)) : 24;
            send_frame(a, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), nb, -1);
        end

        repeat (20) @(negedge clk);
        check("regs_final", regs, flat());
        check("pending_events", 64'(ev_q.size()), 64'h0);
        check("pending_miso", 64'(miso_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
